mealy_pattern_detector: RTL and testbench
=========================================

# mealy_pattern_detector

Parametrised, runtime-programmable Mealy serial-pattern detector. It is the next generation of the team's fixed 4-bit sequence detector, generalised to any pattern of length 1..MAX_LEN. It adds selectable overlapping or non-overlapping matching, input qualification, and a saturating match counter. It sits on a 1-bit serial input stream and flags each bit that completes the programmed pattern, in the same cycle as that bit.

## Interface

**Parameters**
- MAX_LEN, default 8: maximum pattern length in bits; must be ≥ 2.
- LEN_W, default 4: width of cfg_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, default 8: width of match_cnt.

**Ports**
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- cfg_we  in  1  load configuration this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bits [len-1:0] used; bit len-1 is the first bit received.
- cfg_len  in  LEN_W  pattern length; 0 = disabled; values > MAX_LEN are clamped to MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- in_valid  in  1  qualifies in; when 0, the cycle is a bubble.
- in  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- dec  out  1  combinational Mealy match flag.
- match_cnt  out  CNT_W  registered, saturating count of dec pulses.

## Operation

- **Registers**
  - pat_q, len_q, ovl_q: configuration.
  - hist[MAX_LEN-2:0]: accepted bits, newest at bit 0.
  - fill: number of valid history bits, saturating at len_q-1.
  - match_cnt.
- **Reset (rst_n low, async):** pat_q=0, len_q=0, ovl_q=1, hist=0, fill=0, match_cnt=0, so dec=0.
- **States**, derived from len_q and fill:
  - DIS: len_q==0. dec is held at 0. History still shifts, but fill stays 0.
  - FILL: fill < len_q-1. dec=0. An accepted bit increments fill.
  - ARMED: fill == len_q-1. dec can assert.
- **Match:**
  - len_q=1: dec = in_valid & (in == pat_q[0]).
  - Otherwise: dec = in_valid & ARMED & ({hist[len_q-2:0], in} == pat_q[len_q-1:0]).
- **Accepted bit** (in_valid=1, cfg_we=0): hist <= {hist[MAX_LEN-3:0], in}.
  - If dec=1 and ovl_q=0: fill <= 0, so the next match needs len_q fresh bits.
  - If dec=1 and ovl_q=1: fill stays at len_q-1, so the matched bits may begin the next match.
- **Bubble** (in_valid=0): hist, fill and match_cnt hold. dec=0.
- **Config write** (cfg_we=1):
  - pat_q/len_q(clamped)/ovl_q are loaded, and hist=0, fill=0.
  - dec is forced to 0 that cycle, and the in bit of that cycle is discarded.
  - The new configuration governs from the next cycle. match_cnt is unaffected.
- **match_cnt:**
  - cnt_clr=1: match_cnt <= 0. Clear wins over a simultaneous dec.
  - Else if dec=1 and match_cnt != all-ones: increment.
  - At all-ones it holds (saturates).

## Timing

- dec is purely combinational from in, in_valid and registered state. It is valid in the same cycle as the completing bit, with zero latency. Sample dec before the clock edge.
- match_cnt reflects a dec pulse one cycle after that pulse, on the next posedge.
- Config written at edge N applies to bits presented in cycle N+1 onward. The first possible dec is at the len-th accepted bit after the write (1st for len=1).
- Reset asserted mid-stream clears state immediately, without waiting for clk. After deassertion the block is in DIS until configured.
- No combinational path exists from cfg_* or cnt_clr to dec other than the forcing of dec to 0 under cfg_we.

## Test plan

1. **Overlap, len 4:** configure pattern 1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 (all valid) → dec on bits 4 and 7; match_cnt=2 afterward.
2. **Non-overlap vs overlap, len 3:** pattern 111, len 3, overlap=0; six 1s → dec on bits 3 and 6 only. Repeat with overlap=1 → dec on bits 3,4,5,6; match_cnt=4.
3. **Bubbles:** pattern 1011 with in_valid=0 cycles (in toggling) inserted between every bit → dec on the cycle carrying the 4th valid bit only. Bubble cycles never assert dec and do not disturb history.
4. **Reconfigure mid-stream:** after 1,0,1 of pattern 1011, write pattern 01, len 2 with in=1 in the write cycle → no dec that cycle. A following stream 1,0,1 gives dec only on bit 3; the first 1 after the write is not a match.
5. **Counter saturation and clear:** CNT_W=2, len 1, pattern 1; five 1s → match_cnt 1,2,3,3,3. cnt_clr together with dec → match_cnt=0. A subsequent dec gives 1.
6. **Clamp and reset:** cfg_len=15 with MAX_LEN=8 behaves as len 8. Assert rst_n low mid-pattern between edges → dec=0 and match_cnt=0 immediately. After release, any stream → dec=0 (DIS).

Source files
------------

// File: rtl/mealy_pattern_detector.sv
// Programmable Mealy serial-pattern detector: flags the bit that completes the
// programmed pattern in the same cycle, with overlap control and a saturating match count.
//
// state | meaning
// DIS   | len_q == 0, detector disabled, dec held low
// FILL  | fill_q < len_q-1, collecting bits before a match is possible
// ARMED | fill_q == len_q-1, the current bit can complete a match
module mealy_pattern_detector #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cnt_clr,
  output logic               dec,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic [1:0] {ST_DIS, ST_FILL, ST_ARMED} state_t;

  localparam logic [MAX_LEN-1:0] ONE = {{(MAX_LEN-1){1'b0}}, 1'b1};

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  state_t             state;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state = ST_FILL;
    if (len_q == '0)
      state = ST_DIS;
    else if (fill_q == len_q - LEN_W'(1))
      state = ST_ARMED;
  end

  // Next-state logic
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    accept = in_valid & ~cfg_we;

    if (cfg_we) begin
      pat_d  = cfg_pattern;
      len_d  = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept) begin
      hist_d = window[MAX_LEN-2:0];
      unique case (state)
        ST_DIS:   fill_d = '0;
        ST_FILL:  fill_d = fill_q + LEN_W'(1);
        ST_ARMED: if (dec && !ovl_q) fill_d = '0;
        default:  fill_d = '0;
      endcase
    end

    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (dec && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Output logic: newest history bit sits just above the live input bit
  always_comb begin
    window = {hist_q, in};
    mask   = (ONE << len_q) - ONE;
    hit    = ((window ^ pat_q) & mask) == '0;
    dec    = accept & (state == ST_ARMED) & hit;
  end

  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// Scoreboard bench for mealy_pattern_detector: a reference model predicts dec and
// match_cnt per cycle for a default instance and a 2-bit-counter instance.
module tb_mealy_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       dec8, dec2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_hist[$];
  int       m_since;
  int       m_cnt8, m_cnt2;
  bit       exp_q[$];

  always #5 clk = ~clk;

  mealy_pattern_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in(in_bit), .cnt_clr(cnt_clr), .dec(dec8), .match_cnt(cnt8));

  mealy_pattern_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
    .in(in_bit), .cnt_clr(cnt_clr), .dec(dec2), .match_cnt(cnt2));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pat = '0; m_len = 0; m_ovl = 1'b1; m_hist.delete(); m_since = 0;
    m_cnt8 = 0; m_cnt2 = 0;
  endtask

  function automatic bit model_dec(bit v, bit b, bit we);
    if (!v || we || m_len == 0) return 1'b0;
    if (m_since < m_len - 1) return 1'b0;
    if (b != m_pat[0]) return 1'b0;
    for (int k = 1; k < m_len; k++)
      if (m_hist[m_hist.size() - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: drive just after posedge, check at negedge, update model at next posedge.
  task automatic cycle(input string tag, input bit we, input bit v, input bit b, input bit clr);
    bit e, got_e;
    cfg_we = we; in_valid = v; in_bit = b; cnt_clr = clr;
    e = model_dec(v, b, we);
    exp_q.push_back(e);
    @(negedge clk);
    got_e = exp_q.pop_front();
    chk({tag, "_dec8"}, int'(dec8), int'(got_e));
    chk({tag, "_dec2"}, int'(dec2), int'(got_e));
    chk({tag, "_cnt8"}, int'(cnt8), m_cnt8);
    chk({tag, "_cnt2"}, int'(cnt2), m_cnt2);
    @(posedge clk);
    #1;
    if (we) begin
      m_pat = cfg_pattern;
      m_len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
      m_ovl = cfg_overlap;
      m_hist.delete();
      m_since = 0;
    end else if (v) begin
      m_hist.push_back(b);
      if (m_hist.size() > 32) void'(m_hist.pop_front());
      m_since++;
      if (e && !m_ovl) m_since = 0;
    end
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end else if (e) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    cfg_we = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic configure(input bit [7:0] pat, input bit [3:0] len, input bit ovl, input bit b);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    cycle("cfg", 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic send(input string tag, input int n, input bit [15:0] bits);
    for (int i = n - 1; i >= 0; i--) cycle(tag, 1'b0, 1'b1, bits[i], 1'b0);
  endtask

  task automatic clear_cnt();
    cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cnt8", int'(cnt8), 0);
    cycle("dis", 1'b0, 1'b1, 1'b1, 1'b0);

    // Overlap, len 4
    configure(8'b1011, 4'd4, 1'b1, 1'b0);
    send("t1", 7, 16'b1011011);
    chk("t1_total", int'(cnt8), 2);

    // Non-overlap vs overlap, len 3
    clear_cnt();
    configure(8'b111, 4'd3, 1'b0, 1'b1);
    send("t2n", 6, 16'b111111);
    chk("t2n_total", int'(cnt8), 2);
    clear_cnt();
    configure(8'b111, 4'd3, 1'b1, 1'b1);
    send("t2o", 6, 16'b111111);
    chk("t2o_total", int'(cnt8), 4);

    // Bubbles with toggling data between valid bits
    clear_cnt();
    configure(8'b1011, 4'd4, 1'b1, 1'b0);
    begin
      bit [3:0] s;
      s = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        cycle("t3", 1'b0, 1'b1, s[i], 1'b0);
        cycle("t3b", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("t3b", 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("t3_total", int'(cnt8), 1);

    // Reconfigure mid-stream
    clear_cnt();
    send("t4a", 3, 16'b101);
    configure(8'b01, 4'd2, 1'b1, 1'b1);
    send("t4b", 3, 16'b101);
    chk("t4_total", int'(cnt8), 1);

    // Saturation and clear (2-bit counter instance)
    clear_cnt();
    configure(8'b1, 4'd1, 1'b1, 1'b1);
    send("t5", 5, 16'b11111);
    chk("t5_sat2", int'(cnt2), 3);
    chk("t5_cnt8", int'(cnt8), 5);
    cycle("t5clr", 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_clr2", int'(cnt2), 0);
    cycle("t5post", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_post2", int'(cnt2), 1);

    // Clamp: len 15 acts as len 8
    clear_cnt();
    configure(8'b10110011, 4'd15, 1'b0, 1'b0);
    send("t6", 12, 16'b0011_10110011);
    send("t6", 8, 16'b10110011);

    // Asynchronous reset mid-pattern
    send("t6r", 5, 16'b10110);
    cfg_we = 1'b0; in_valid = 1'b1; in_bit = 1'b0; cnt_clr = 1'b0;
    @(negedge clk);
    chk("t6r_pre", int'(cnt8), m_cnt8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dec8", int'(dec8), 0);
    chk("arst_cnt8", int'(cnt8), 0);
    chk("arst_cnt2", int'(cnt2), 0);
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    send("post_rst", 8, 16'b10110011);
    send("post_rst", 4, 16'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
